// File: rtl/frame_capture_ctrl.sv
// OV7670 capture sequencer: pairs RGB565 bytes into RGB332 pixels and writes them to the frame buffer.
// Optional macro FRAME_CAPTURE_TEST_PATTERN_EN adds a TEST_PATTERN input that substitutes colour bars.
module frame_capture_ctrl #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int ADDR_W        = 15
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        DATA,
  input  logic              FREEZE,
`ifdef FRAME_CAPTURE_TEST_PATTERN_EN
  input  logic              TEST_PATTERN,
`endif
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              W_EN,
  output logic              FRAME_DONE,
  output logic              FRAME_ERR,
  output logic              BUSY
);

  localparam int XW = $clog2(SCREEN_WIDTH + 1);
  localparam int YW = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [XW-1:0]     X_LIMIT  = XW'(SCREEN_WIDTH);
  localparam logic [YW-1:0]     Y_LAST   = YW'(SCREEN_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SCREEN_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    LINE_WAIT,
    CAPTURE,
    FRAME_END
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] row_base;
  logic              phase;
  logic [7:0]        hi_byte;
  logic [7:0]        pixel;

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // VSYNC while a frame is open always aborts it, even in the middle of a line.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!FREEZE && VSYNC) state_next = ARMED;
      ARMED:     if (!VSYNC) state_next = LINE_WAIT;
      LINE_WAIT: begin
        if (VSYNC)     state_next = IDLE;
        else if (HREF) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (VSYNC)      state_next = IDLE;
        else if (!HREF) state_next = (y == Y_LAST) ? FRAME_END : LINE_WAIT;
      end
      FRAME_END: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    BUSY       = (state != IDLE);
    FRAME_DONE = (state == FRAME_END);
  end

  always_comb begin
    pixel = {hi_byte[7:5], hi_byte[2:0], DATA[4:3]};
`ifdef FRAME_CAPTURE_TEST_PATTERN_EN
    if (TEST_PATTERN) begin
      if (32'(x) < 32'd59)       pixel = 8'hE0;
      else if (32'(x) < 32'd118) pixel = 8'h1C;
      else                       pixel = 8'h03;
    end
`endif
  end

  // Pixel position is tracked incrementally; row_base advances one row per line so no multiply is needed.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      x         <= '0;
      y         <= '0;
      row_base  <= '0;
      phase     <= 1'b0;
      hi_byte   <= '0;
      W_ADDR    <= '0;
      W_DATA    <= '0;
      W_EN      <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      W_EN      <= 1'b0;
      FRAME_ERR <= 1'b0;
      case (state)
        ARMED: begin
          if (!VSYNC) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            phase    <= 1'b0;
          end
        end
        LINE_WAIT: begin
          if (VSYNC) begin
            FRAME_ERR <= 1'b1;
          end else if (HREF) begin
            hi_byte <= DATA;
            phase   <= 1'b1;
          end
        end
        CAPTURE: begin
          if (VSYNC) begin
            FRAME_ERR <= 1'b1;
          end else if (HREF) begin
            if (!phase) begin
              hi_byte <= DATA;
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (x < X_LIMIT) begin
                W_EN   <= 1'b1;
                W_ADDR <= row_base + ADDR_W'(x);
                W_DATA <= pixel;
                x      <= x + XW'(1);
              end
            end
          end else begin
            x        <= '0;
            phase    <= 1'b0;
            y        <= y + YW'(1);
            row_base <= row_base + ROW_STEP;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Scoreboard bench for frame_capture_ctrl: random camera frames feed a queue of expected writes/events.
// A reduced screen geometry keeps whole frames short while exercising the same rules.
module tb_frame_capture_ctrl;

  localparam int W       = 128;
  localparam int H       = 5;
  localparam int AW      = 15;
  localparam int NFRAMES = 16;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic          VSYNC;
  logic          HREF;
  logic [7:0]    DATA;
  logic          FREEZE;
`ifdef FRAME_CAPTURE_TEST_PATTERN_EN
  logic          TEST_PATTERN;
`endif
  logic [AW-1:0] W_ADDR;
  logic [7:0]    W_DATA;
  logic          W_EN;
  logic          FRAME_DONE;
  logic          FRAME_ERR;
  logic          BUSY;

  frame_capture_ctrl #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .ADDR_W       (AW)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .VSYNC       (VSYNC),
    .HREF        (HREF),
    .DATA        (DATA),
    .FREEZE      (FREEZE),
`ifdef FRAME_CAPTURE_TEST_PATTERN_EN
    .TEST_PATTERN(TEST_PATTERN),
`endif
    .W_ADDR      (W_ADDR),
    .W_DATA      (W_DATA),
    .W_EN        (W_EN),
    .FRAME_DONE  (FRAME_DONE),
    .FRAME_ERR   (FRAME_ERR),
    .BUSY        (BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int addr;
    int data;
    int stamp;
    int frame;
  } wr_t;

  typedef struct {
    int kind;
    int frame;
  } ev_t;

  wr_t  wq[$];
  ev_t  eq[$];
  int   checks     = 0;
  int   errors     = 0;
  int   cyc        = 0;
  bit   mon_en     = 1'b0;
  bit   prev_wen   = 1'b0;
  bit   busy_watch = 1'b0;
  int   busy_hits  = 0;
  bit   prev_open  = 1'b0;
  int   prev_frame = 0;
  bit   tp_on      = 1'b0;
  wr_t  mon_wr;

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic report_fail(input string name, input int actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got 0x%0h with nothing expected (cycle %0d)", name, actual, cyc);
  endtask

  task automatic handle_event(input int kind);
    ev_t ev;
    int  pending;
    if (eq.size() == 0) begin
      report_fail(kind == 0 ? "unexpected_frame_done" : "unexpected_frame_err", kind);
    end else begin
      ev = eq.pop_front();
      check_output("event_kind", kind, ev.kind);
      pending = 0;
      foreach (wq[i]) if (wq[i].frame == ev.frame) pending++;
      check_output("writes_missing_at_event", pending, 0);
    end
  endtask

  // Monitor: every write or status pulse the DUT presents is matched against the scoreboard.
  always @(negedge CLOCK) begin
    if (mon_en) begin
      if (W_EN) begin
        check_output("w_en_back_to_back", int'(prev_wen), 0);
        if (wq.size() == 0) begin
          report_fail("unexpected_write", int'(W_ADDR));
        end else begin
          mon_wr = wq.pop_front();
          check_output("w_addr", int'(W_ADDR), mon_wr.addr);
          check_output("w_data", int'(W_DATA), mon_wr.data);
          check_output("write_latency", cyc, mon_wr.stamp);
        end
      end
      prev_wen = W_EN;
      if (busy_watch && BUSY) busy_hits++;
      if (FRAME_DONE) handle_event(0);
      if (FRAME_ERR)  handle_event(1);
    end
  end

  task automatic apply_stimulus(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge CLOCK);
    VSYNC = vs;
    HREF  = hr;
    DATA  = d;
  endtask

  function automatic int model_pixel(input logic [7:0] hi, input logic [7:0] lo, input int col);
    if (tp_on) begin
      if (col < 59)  return 'hE0;
      if (col < 118) return 'h1C;
      return 'h03;
    end
    return int'({hi[7:5], hi[2:0], lo[4:3]});
  endfunction

  function automatic int pick_line_len();
    int r;
    r = $urandom_range(0, 3);
    if (r <= 1) return 2 * W;
    if (r == 2) return $urandom_range(1, 2 * W - 1);
    return $urandom_range(2 * W + 1, 2 * W + 9);
  endfunction

  // freeze_line >= 0 raises FREEZE at that line; -1 toggles FREEZE randomly per line.
  task automatic run_frame(input int f, input bit freeze_start, input int nlines,
                           input bit directed, input int freeze_line, input bit do_reset);
    logic [7:0] dir_bytes [4];
    logic [7:0] hi;
    logic [7:0] b;
    bit         captured;
    int         n;
    wr_t        wr;
    ev_t        ev;
    dir_bytes = '{8'hF8, 8'h1F, 8'h07, 8'hE0};
    hi = '0;
    if (prev_open) begin
      ev.kind  = 1;
      ev.frame = prev_frame;
      eq.push_back(ev);
      prev_open = 1'b0;
    end
    FREEZE = freeze_start;
`ifdef FRAME_CAPTURE_TEST_PATTERN_EN
    tp_on        = directed ? 1'b0 : 1'($urandom_range(0, 1));
    TEST_PATTERN = tp_on;
`endif
    repeat (3) apply_stimulus(1'b1, 1'b0, 8'h00);
    repeat (2) apply_stimulus(1'b0, 1'b0, 8'h00);
    captured   = !freeze_start;
    busy_hits  = 0;
    busy_watch = !captured;
    for (int y = 0; y < nlines; y++) begin
      if (freeze_line < 0)       FREEZE = 1'($urandom_range(0, 1));
      else if (y == freeze_line) FREEZE = 1'b1;
      n = (directed && y == 0) ? 2 * W + 9 : pick_line_len();
      for (int i = 0; i < n; i++) begin
        b = (directed && y == 0 && i < 4) ? dir_bytes[i] : 8'($urandom);
        apply_stimulus(1'b0, 1'b1, b);
        if (i % 2 == 0) begin
          hi = b;
        end else if (captured && i / 2 < W) begin
          wr.addr  = y * W + i / 2;
          wr.data  = model_pixel(hi, b, i / 2);
          if (directed && y == 0 && i == 1) wr.data = 'hE3;
          if (directed && y == 0 && i == 3) wr.data = 'h1C;
          wr.stamp = cyc + 1;
          wr.frame = f;
          wq.push_back(wr);
        end
        if (do_reset && y == 3 && i == 79) begin
          @(negedge CLOCK);
          RESET = 1'b1;
          @(posedge CLOCK);
          #1;
          check_output("reset_mid_w_en", int'(W_EN), 0);
          check_output("reset_mid_busy", int'(BUSY), 0);
          check_output("reset_mid_err", int'(FRAME_ERR), 0);
          wq.delete();
          eq.delete();
          @(negedge CLOCK);
          RESET = 1'b0;
          HREF  = 1'b0;
          repeat (4) apply_stimulus(1'b0, 1'b0, 8'h00);
          return;
        end
      end
      if (captured && y == H - 1) begin
        ev.kind  = 0;
        ev.frame = f;
        eq.push_back(ev);
      end
      repeat ((y == H - 1) ? 4 : $urandom_range(1, 3)) apply_stimulus(1'b0, 1'b0, 8'h00);
    end
    if (captured && nlines < H) begin
      prev_open  = 1'b1;
      prev_frame = f;
    end
    repeat (3) apply_stimulus(1'b0, 1'b0, 8'h00);
    if (!captured) begin
      busy_watch = 1'b0;
      check_output("busy_while_frozen", busy_hits, 0);
    end
  endtask

  initial begin
    RESET  = 1'b1;
    VSYNC  = 1'b0;
    HREF   = 1'b0;
    DATA   = 8'h00;
    FREEZE = 1'b0;
`ifdef FRAME_CAPTURE_TEST_PATTERN_EN
    TEST_PATTERN = 1'b0;
`endif
    repeat (3) @(negedge CLOCK);
    check_output("reset_w_en", int'(W_EN), 0);
    check_output("reset_w_addr", int'(W_ADDR), 0);
    check_output("reset_w_data", int'(W_DATA), 0);
    check_output("reset_frame_done", int'(FRAME_DONE), 0);
    check_output("reset_frame_err", int'(FRAME_ERR), 0);
    check_output("reset_busy", int'(BUSY), 0);
    RESET  = 1'b0;
    mon_en = 1'b1;

    run_frame(0, 1'b0, H, 1'b1, 99, 1'b0);
    run_frame(1, 1'b0, 2, 1'b0, 99, 1'b0);
    run_frame(2, 1'b0, H, 1'b0, 2, 1'b0);
    run_frame(3, 1'b1, H, 1'b0, 0, 1'b0);
    run_frame(4, 1'b0, H, 1'b0, 99, 1'b1);
    for (int f = 5; f < NFRAMES; f++) begin
      if ($urandom_range(0, 3) == 0) run_frame(f, 1'b1, $urandom_range(1, H), 1'b0, -1, 1'b0);
      else if ($urandom_range(0, 1) == 0) run_frame(f, 1'b0, H, 1'b0, -1, 1'b0);
      else run_frame(f, 1'b0, $urandom_range(1, H - 1), 1'b0, -1, 1'b0);
    end

    if (prev_open) begin
      eq.push_back('{kind: 1, frame: prev_frame});
      prev_open = 1'b0;
    end
    FREEZE = 1'b1;
    repeat (3) apply_stimulus(1'b1, 1'b0, 8'h00);
    repeat (20) apply_stimulus(1'b0, 1'b0, 8'h00);
    check_output("writes_left", wq.size(), 0);
    check_output("events_left", eq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    report_fail("watchdog_timeout", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
Sequences the OV7670 capture path into the M9K frame buffer write port. Runs on the camera pixel clock and tracks VSYNC/HREF framing. Pairs RGB565 bytes into RGB332 pixels and generates write address, data and enable for a SCREEN_WIDTH x SCREEN_HEIGHT buffer. Provides frame-done/error status and a FREEZE control so the image processor can hold a stable frame.

Parameters:
SCREEN_WIDTH, 176, pixels per stored row
SCREEN_HEIGHT, 144, stored rows per frame
ADDR_W, 15, write address width

Ports:
CLOCK  input  1  camera pixel clock (pclk); all logic on rising edge
RESET  input  1  synchronous, active-high reset
VSYNC  input  1  camera VSYNC, high = frame boundary
HREF  input  1  camera HREF, high = valid bytes on DATA
DATA  input  8  camera byte bus
FREEZE  input  1  1 = do not start new frames
W_ADDR  output  ADDR_W  M9K write address
W_DATA  output  8  RGB332 pixel
W_EN  output  1  M9K write enable
FRAME_DONE  output  1  one-cycle pulse, full frame stored
FRAME_ERR  output  1  one-cycle pulse, frame aborted by early VSYNC
BUSY  output  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE; x=0, y=0, row_base=0, phase=0; all outputs 0.
- States: IDLE, ARMED, LINE_WAIT, CAPTURE, FRAME_END.
- IDLE: FREEZE==0 and VSYNC==1 -> ARMED. FREEZE is sampled only here; a frame in progress always completes.
- ARMED: VSYNC==0 -> LINE_WAIT; clear x, y, row_base, phase.
- LINE_WAIT: VSYNC==1 -> IDLE with FRAME_ERR pulse. HREF==1 -> CAPTURE; latch DATA as hi byte; phase=1.
- CAPTURE, HREF==1:
  - phase==0: latch hi byte; phase=1.
  - phase==1: pixel = {hi[7:5], hi[2:0], DATA[4:3]}; phase=0.
  - If x<SCREEN_WIDTH: next cycle W_EN=1, W_ADDR=row_base+x, W_DATA=pixel; x++.
  - If x>=SCREEN_WIDTH: pixel dropped; x saturates.
- CAPTURE, HREF==0 (end of line):
  - A dangling hi byte (phase==1) is discarded.
  - x=0, phase=0, y++, row_base+=SCREEN_WIDTH.
  - New y==SCREEN_HEIGHT -> FRAME_END; else LINE_WAIT.
- CAPTURE, VSYNC==1: overrides HREF; -> IDLE, FRAME_ERR pulse, no write that cycle.
- FRAME_END: FRAME_DONE=1 for exactly one cycle -> IDLE.
- Latency: W_EN/W_ADDR/W_DATA are registered and valid the cycle after the second byte is sampled. W_EN is never high for two consecutive cycles.
- Address is computed incrementally (row_base adder); no multiplier. Max address = SCREEN_WIDTH*SCREEN_HEIGHT-1; never exceeded.
- Extra camera lines after y==SCREEN_HEIGHT cannot occur (FRAME_END already reached); next frame requires a new VSYNC.
- RESET mid-frame: outputs 0 the next cycle; next write after reset goes to address 0.

Optional Feature:
FRAME_CAPTURE_TEST_PATTERN_EN
- Defined: adds input TEST_PATTERN (1 bit). When 1, W_DATA is replaced by bars based on x:
  - x<59 -> 8'hE0
  - x<118 -> 8'h1C
  - else 8'h03
  - Timing, addressing and framing are unchanged.
- Undefined: no TEST_PATTERN port; W_DATA always comes from camera bytes.

Test Plan:
- Full frame: VSYNC pulse, then 144 HREF lines of 352 bytes -> 25344 W_EN pulses; addresses 0..25343 in order; one FRAME_DONE after the last line; FRAME_ERR never set.
- Byte pairing: hi=8'hF8, lo=8'h1F -> W_DATA 8'hE3. hi=8'h07, lo=8'hE0 -> W_DATA 8'h1C. Each write appears the cycle after the lo byte.
- Long/odd line: line 0 of 361 bytes -> exactly 176 writes (addr 0..175); trailing byte dropped; line 1 first write at addr 176.
- Early VSYNC: VSYNC high after 10 lines -> FRAME_ERR pulse, no FRAME_DONE. Following full frame starts at addr 0 and completes normally.
- FREEZE: high while IDLE -> zero W_EN across a full camera frame, BUSY=0. Asserted at line 50 of an active frame -> frame completes with FRAME_DONE; next frame ignored.
- RESET in CAPTURE at x=40, y=3 -> W_EN=0 and BUSY=0 next cycle; next frame's first write at addr 0.
